// File: rtl/lane_ser_pkg.sv
// Shared types and lane-search helper for lane_serializer_4.
// Optional LANE_SER_MASK_EN build uses next_set_lane to skip masked lanes.
package lane_ser_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [1:0] SEL_LAST = 2'd3;

    // Smallest set lane strictly above cur; returns cur when none remains.
    function automatic logic [1:0] next_set_lane(input logic [3:0] mask, input logic [1:0] cur);
        logic [1:0] r;
        r = cur;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(cur) && mask[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_4.sv
// Purpose: plain 4:1 lane mux driven by lane_serializer_4.
// Latency: purely combinational.
// Backpressure: none; output follows sel and data inputs.
module mux_4 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/lane_serializer_4.sv
// Purpose: hold a 4-lane word on the external mux_4 and step its select, streaming lanes as beats.
// Latency: first beat valid the cycle after the input handshake; 4 beats per word, no bubble between words.
// Backpressure: out_ready low freezes select and lanes; in_ready only opens in IDLE or on an accepted last beat.
// Optional: LANE_SER_MASK_EN adds in_mask to skip lanes whose mask bit is clear.
module lane_serializer_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
`ifdef LANE_SER_MASK_EN
    input  logic [3:0]       in_mask,
`endif
    output logic [WIDTH-1:0] mux_a,
    output logic [WIDTH-1:0] mux_b,
    output logic [WIDTH-1:0] mux_c,
    output logic [WIDTH-1:0] mux_d,
    output logic [1:0]       mux_sel,
    input  logic [WIDTH-1:0] mux_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);
    import lane_ser_pkg::*;

    state_t     state;
    logic       at_last;
    logic       load;
    logic [1:0] load_sel;
    logic       load_last;
    logic       load_empty;
    logic [1:0] step_sel;
    logic       step_last;

`ifdef LANE_SER_MASK_EN
    logic [3:0] mask_q;

    always_comb begin
        load_empty = (in_mask == 4'b0000);
        load_sel   = in_mask[0] ? 2'd0 : next_set_lane(in_mask, 2'd0);
        load_last  = !load_empty && (next_set_lane(in_mask, load_sel) == load_sel);
        step_sel   = next_set_lane(mask_q, mux_sel);
        step_last  = (next_set_lane(mask_q, step_sel) == step_sel);
    end

    assign at_last = out_last;
`else
    always_comb begin
        load_empty = 1'b0;
        load_sel   = 2'd0;
        load_last  = 1'b0;
        step_sel   = mux_sel + 2'd1;
        step_last  = (step_sel == SEL_LAST);
    end

    assign at_last = (mux_sel == SEL_LAST);
`endif

    assign in_ready = (state == IDLE) || (state == SHIFT && at_last && out_ready);
    assign load     = in_valid && in_ready;
    assign out_data = mux_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mux_sel   <= 2'd0;
            mux_a     <= '0;
            mux_b     <= '0;
            mux_c     <= '0;
            mux_d     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef LANE_SER_MASK_EN
            mask_q    <= 4'b0000;
`endif
        end else if (load) begin
            // Covers both the IDLE accept and the no-bubble reload on the last beat.
            mux_a     <= in_a;
            mux_b     <= in_b;
            mux_c     <= in_c;
            mux_d     <= in_d;
`ifdef LANE_SER_MASK_EN
            mask_q    <= in_mask;
`endif
            mux_sel   <= load_sel;
            out_last  <= load_last;
            state     <= load_empty ? IDLE : SHIFT;
            out_valid <= !load_empty;
        end else if (state == SHIFT && out_ready) begin
            if (!at_last) begin
                mux_sel  <= step_sel;
                out_last <= step_last;
            end else begin
                state     <= IDLE;
                mux_sel   <= 2'd0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lane_serializer_4.sv
// Bench for lane_serializer_4 wired to mux_4; expected beats are queued at issue and checked by a monitor.
// Define LANE_SER_MASK_EN for both RTL and bench to exercise the lane mask.
module tb_lane_serializer_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b, in_c, in_d;
    logic [W-1:0] mux_a, mux_b, mux_c, mux_d;
    logic [1:0]   mux_sel;
    logic [W-1:0] mux_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
`ifdef LANE_SER_MASK_EN
    logic [3:0]   in_mask;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   lane;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    lane_serializer_4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
`ifdef LANE_SER_MASK_EN
        .in_mask(in_mask),
`endif
        .mux_a(mux_a), .mux_b(mux_b), .mux_c(mux_c), .mux_d(mux_d),
        .mux_sel(mux_sel), .mux_out(mux_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    mux_4 #(.WIDTH(W)) u_mux (
        .a(mux_a), .b(mux_b), .c(mux_c), .d(mux_d), .sel(mux_sel), .y(mux_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=%0h required=none", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(out_data), 32'(e.data));
                chk("beat_sel", 32'(mux_sel), 32'(e.lane));
                chk("beat_last", 32'(out_last), 32'(e.last));
                chk("beat_in_ready", 32'(in_ready), 32'(e.last));
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [3:0] m, input bit hold);
        logic [3:0] ln [4];
        int         n;
        int         hi;
        ln[0] = a; ln[1] = b; ln[2] = c; ln[3] = d;
        in_a = a; in_b = b; in_c = c; in_d = d;
`ifdef LANE_SER_MASK_EN
        in_mask = m;
`endif
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        hi = -1;
        for (int i = 0; i < 4; i++) if (m[i]) hi = i;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) exp_q.push_back('{data: ln[i], lane: 2'(i), last: (i == hi)});
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain(output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 100) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int c0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
`ifdef LANE_SER_MASK_EN
        in_mask = 4'hF;
`endif
        out_ready = 1'b1;

        #3;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        chk("reset_mux_sel", 32'(mux_sel), 32'd0);
        chk("reset_mux_a", 32'(mux_a), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word: four consecutive beats then IDLE.
        send(4'h0, 4'h1, 4'h2, 4'h3, 4'hF, 1'b0);
        drain(n);
        chk("single_cycles", 32'(n), 32'd4);
        @(posedge clk);
        #1;
        chk("single_idle_in_ready", 32'(in_ready), 32'd1);
        chk("single_idle_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back: 8 beats occupy 8 cycles, so 8 edges elapse until the block is idle again.
        send(4'h0, 4'h1, 4'h2, 4'h3, 4'hF, 1'b1);
        c0 = cyc;
        send(4'hA, 4'hB, 4'hC, 4'hD, 4'hF, 1'b0);
        drain(n);
        @(posedge clk);
        #1;
        chk("b2b_cycles", 32'(cyc - c0), 32'd8);
        chk("b2b_idle_out_valid", 32'(out_valid), 32'd0);

        // Stall three edges on beat 1.
        send(4'h5, 4'h6, 4'h7, 4'h8, 4'hF, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_data", 32'(out_data), 32'h6);
            chk("stall_sel", 32'(mux_sel), 32'd1);
            chk("stall_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        drain(n);
        @(posedge clk);
        #1;

        // Asynchronous reset after beat 1; remaining beats are dropped.
        send(4'h9, 4'hA, 4'hB, 4'hC, 4'hF, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mux_sel", 32'(mux_sel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_mux_a", 32'(mux_a), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 1'b0);
        drain(n);
        @(posedge clk);
        #1;

        // Inputs wander with in_valid low; beats must follow the latched word.
        send(4'hE, 4'hF, 4'h1, 4'h2, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            in_a = 4'($urandom);
            in_b = 4'($urandom);
            in_c = 4'($urandom);
            in_d = 4'($urandom);
            @(posedge clk);
            #1;
        end
        drain(n);
        @(posedge clk);
        #1;
        chk("toggle_idle_in_ready", 32'(in_ready), 32'd1);

`ifdef LANE_SER_MASK_EN
        send(4'h0, 4'h1, 4'h2, 4'h3, 4'b1010, 1'b0);
        drain(n);
        @(posedge clk);
        #1;
        send(4'h5, 4'h5, 4'h5, 4'h5, 4'b0000, 1'b0);
        chk("mask0_in_ready", 32'(in_ready), 32'd1);
        chk("mask0_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("mask0_in_ready_later", 32'(in_ready), 32'd1);
        chk("mask0_out_valid_later", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
